// File: rtl/dcache_sa_wb_if.sv
// Pipeline-side (p1_*) and line-memory-side (mem_*) signals of the data cache.
// Signal suffixes are from the cache's point of view.
interface dcache_sa_wb_if #(
  parameter int LINE_BITS = 256
);
  logic [31:0]          p1_addr_i;
  logic [31:0]          p1_data_i;
  logic                 p1_MemRead_i;
  logic                 p1_MemWrite_i;
  logic [31:0]          p1_data_o;
  logic                 p1_stall_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [31:0]          mem_addr_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;

  modport slave (
    input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );

  modport master (
    output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/dcache_sa_wb.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU
// replacement and saturating hit/miss counters.
//  state  | meaning
//  IDLE   | serve hits; on a miss pick victim, go to WB (dirty) or REFILL
//  WB     | write victim line back, wait for ack
//  REFILL | read requested line, capture it on ack
//  FILL   | install captured line into victim way; request retries as a hit
module dcache_sa_wb #(
  parameter int WAYS      = 2,
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256,
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dcache_sa_wb_if.slave    bus,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);
  localparam int OFF    = $clog2(LINE_BITS / 8);
  localparam int IDX    = $clog2(SETS);
  localparam int TAG_W  = 32 - OFF - IDX;
  localparam int WSEL_W = OFF - 2;
  localparam int AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WB     = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;
  localparam logic [1:0] S_FILL   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [AGE_W-1:0]     victim_q, victim_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;
  logic [SETS-1:0]      valid_q [WAYS];
  logic [SETS-1:0]      valid_d [WAYS];
  logic [SETS-1:0]      dirty_q [WAYS];
  logic [SETS-1:0]      dirty_d [WAYS];
  logic [TAG_W-1:0]     tag_q [WAYS][SETS];
  logic [TAG_W-1:0]     tag_d [WAYS][SETS];
  logic [AGE_W-1:0]     age_q [WAYS][SETS];
  logic [AGE_W-1:0]     age_d [WAYS][SETS];
  logic [LINE_BITS-1:0] data_q [WAYS][SETS];
  logic [LINE_BITS-1:0] data_d;
  logic                 data_we;
  logic [AGE_W-1:0]     data_way;

  logic                 req, is_store, hit, found_inv, acc;
  logic [AGE_W-1:0]     hit_way, victim, acc_way;
  logic [TAG_W-1:0]     req_tag;
  logic [IDX-1:0]       req_idx;
  logic [WSEL_W-1:0]    word_sel;
  logic [LINE_BITS-1:0] hit_line;
  logic [31:0]          hit_word;
  logic                 unused_addr_bits;

  assign req              = bus.p1_MemRead_i | bus.p1_MemWrite_i;
  assign is_store         = bus.p1_MemWrite_i;
  assign req_tag          = bus.p1_addr_i[31 -: TAG_W];
  assign req_idx          = bus.p1_addr_i[OFF +: IDX];
  assign word_sel         = bus.p1_addr_i[2 +: WSEL_W];
  assign unused_addr_bits = ^bus.p1_addr_i[1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
    hit_line = data_q[hit_way][req_idx];
    hit_word = hit_line[{word_sel, 5'd0} +: 32];
  end

  // Invalid ways are filled lowest-index first before any eviction happens.
  always_comb begin
    found_inv = 1'b0;
    victim    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[w][req_idx]) begin
        found_inv = 1'b1;
        victim    = AGE_W'(w);
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w][req_idx] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    line_d     = line_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    age_d      = age_q;
    data_we    = 1'b0;
    data_way   = hit_way;
    data_d     = hit_line;
    acc        = 1'b0;
    acc_way    = hit_way;
    case (state_q)
      S_IDLE: begin
        if (req && hit) begin
          acc       = 1'b1;
          hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
          if (is_store) begin
            data_we = 1'b1;
            data_d[{word_sel, 5'd0} +: 32] = bus.p1_data_i;
            dirty_d[hit_way][req_idx]      = 1'b1;
          end
        end else if (req) begin
          victim_d   = victim;
          miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
          state_d    = (valid_q[victim][req_idx] && dirty_q[victim][req_idx]) ? S_WB : S_REFILL;
        end
      end
      S_WB: begin
        if (bus.mem_ack_i) state_d = S_REFILL;
      end
      S_REFILL: begin
        if (bus.mem_ack_i) begin
          line_d  = bus.mem_data_i;
          state_d = S_FILL;
        end
      end
      default: begin
        data_we                    = 1'b1;
        data_way                   = victim_q;
        data_d                     = line_q;
        valid_d[victim_q][req_idx] = 1'b1;
        dirty_d[victim_q][req_idx] = 1'b0;
        tag_d[victim_q][req_idx]   = req_tag;
        state_d                    = S_IDLE;
      end
    endcase
    // Ages stay a permutation: only ways younger than the touched one move.
    if (acc) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w][req_idx] < age_q[acc_way][req_idx])
          age_d[w][req_idx] = age_q[w][req_idx] + AGE_W'(1);
      end
      age_d[acc_way][req_idx] = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      victim_q   <= '0;
      line_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
        for (int s = 0; s < SETS; s++) begin
          tag_q[w][s] <= '0;
          age_q[w][s] <= AGE_W'(w);
        end
      end
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      line_q     <= line_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
      age_q      <= age_d;
    end
  end

  // Line storage carries no reset; valid bits gate every use of it.
  always_ff @(posedge clk_i) begin
    if (data_we) data_q[data_way][req_idx] <= data_d;
  end

  always_comb begin
    bus.mem_addr_o = '0;
    if (state_q == S_WB)
      bus.mem_addr_o = {tag_q[victim_q][req_idx], req_idx, {OFF{1'b0}}};
    else if (state_q == S_REFILL)
      bus.mem_addr_o = {req_tag, req_idx, {OFF{1'b0}}};
  end

  assign bus.mem_data_o   = (state_q == S_WB) ? data_q[victim_q][req_idx] : '0;
  assign bus.mem_enable_o = (state_q == S_WB) || (state_q == S_REFILL);
  assign bus.mem_write_o  = (state_q == S_WB);
  assign bus.p1_stall_o   = ~rst_i & req & ((state_q != S_IDLE) | ~hit);
  assign bus.p1_data_o    = rst_i ? '0 : hit_word;
  assign hit_cnt_o        = hit_cnt_q;
  assign miss_cnt_o       = miss_cnt_q;
endmodule

// File: tb/tb_dcache_sa_wb.sv
// Directed bench for dcache_sa_wb (2 ways, 16 sets) against a line memory that
// acks 10 cycles after mem_enable_o rises.
module tb_dcache_sa_wb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] hit_cnt, miss_cnt;
  logic        mdl_ack = 1'b0;
  logic        spur_ack = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic [255:0] mem_lines [64];
  int           en_cycles = 0;
  int           wb_count = 0;
  int           rf_count = 0;
  logic [31:0]  last_wb_addr = '0;
  logic [255:0] last_wb_data = '0;
  logic [31:0]  last_rf_addr = '0;

  dcache_sa_wb_if #(.LINE_BITS(256)) bus ();

  dcache_sa_wb #(.WAYS(2), .SETS(16), .LINE_BITS(256), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  assign bus.mem_ack_i = mdl_ack | spur_ack;

  always #5 clk = ~clk;

  // Line memory: word w of line L = 0x11111111*(w+1) ^ (L << 24)
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_data_i = '0;
    for (int l = 0; l < 64; l++)
      for (int w = 0; w < 8; w++)
        mem_lines[l][w*32 +: 32] = (32'h11111111 * 32'(w + 1)) ^ (32'(l) << 24);
    forever begin
      @(posedge clk);
      #1;
      mdl_ack = 1'b0;
      if (rst || !bus.mem_enable_o) begin
        cnt = 0;
      end else begin
        en_cycles++;
        cnt++;
        if (cnt == 11) begin
          cnt = 0;
          mdl_ack = 1'b1;
          if (bus.mem_write_o) begin
            mem_lines[bus.mem_addr_o[10:5]] = bus.mem_data_o;
            wb_count++;
            last_wb_addr = bus.mem_addr_o;
            last_wb_data = bus.mem_data_o;
          end else begin
            bus.mem_data_i = mem_lines[bus.mem_addr_o[10:5]];
            rf_count++;
            last_rf_addr = bus.mem_addr_o;
          end
        end
      end
    end
  end

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic rd,
                        input logic wr, output int stalls, output logic [31:0] rdata);
    bus.p1_addr_i     = a;
    bus.p1_data_i     = d;
    bus.p1_MemRead_i  = rd;
    bus.p1_MemWrite_i = wr;
    stalls = 0;
    rdata  = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.p1_stall_o) begin
        rdata = bus.p1_data_o;
        break;
      end
      stalls++;
    end
    @(posedge clk);
    #1;
    bus.p1_MemRead_i  = 1'b0;
    bus.p1_MemWrite_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.p1_addr_i = '0; bus.p1_data_i = '0;
    bus.p1_MemRead_i = 1'b1; bus.p1_MemWrite_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.p1_stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", bus.p1_stall_o); end
    checks++; if (bus.mem_enable_o !== 1'b0) begin errors++; $display("FAIL rst_enable: got %b expected 0", bus.mem_enable_o); end
    checks++; if (bus.p1_data_o !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", bus.p1_data_o); end
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got hit %0d miss %0d expected 0 0", hit_cnt, miss_cnt); end
    bus.p1_MemRead_i = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_clean_miss();
    int st; logic [31:0] rd;
    access(32'h000, 32'h0, 1'b1, 1'b0, st, rd);
    checks++; if (st != 13) begin errors++; $display("FAIL miss_stall: got %0d expected 13", st); end
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL miss_data: got %h expected 11111111", rd); end
    checks++; if (last_rf_addr !== 32'h000 || rf_count != 1 || wb_count != 0) begin errors++; $display("FAIL miss_traffic: got rf@%h rf %0d wb %0d expected rf@0 1 0", last_rf_addr, rf_count, wb_count); end
    checks++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin errors++; $display("FAIL miss_cnt: got hit %0d miss %0d expected 1 1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_hit();
    int st, en0; logic [31:0] rd;
    en0 = en_cycles;
    access(32'h004, 32'h0, 1'b1, 1'b0, st, rd);
    checks++; if (st != 0) begin errors++; $display("FAIL hit_stall: got %0d expected 0", st); end
    checks++; if (rd !== 32'h22222222) begin errors++; $display("FAIL hit_data: got %h expected 22222222", rd); end
    checks++; if (hit_cnt !== 32'd2 || en_cycles != en0) begin errors++; $display("FAIL hit_cnt_traffic: got hit %0d en %0d expected 2 %0d", hit_cnt, en_cycles, en0); end
  endtask

  task automatic test_dirty_evict();
    int st; logic [31:0] rd;
    access(32'h000, 32'hDEADBEEF, 1'b0, 1'b1, st, rd);
    checks++; if (st != 0 || hit_cnt !== 32'd3) begin errors++; $display("FAIL store_hit: got stall %0d hit %0d expected 0 3", st, hit_cnt); end
    access(32'h200, 32'h0, 1'b1, 1'b0, st, rd);
    checks++; if (st != 13 || rd !== 32'h01111111) begin errors++; $display("FAIL fill_way1: got stall %0d data %h expected 13 01111111", st, rd); end
    checks++; if (wb_count != 0 || miss_cnt !== 32'd2 || hit_cnt !== 32'd4) begin errors++; $display("FAIL fill_way1_cnt: got wb %0d miss %0d hit %0d expected 0 2 4", wb_count, miss_cnt, hit_cnt); end
    access(32'h400, 32'h0, 1'b1, 1'b0, st, rd);
    checks++; if (st != 24 || rd !== 32'h31111111) begin errors++; $display("FAIL evict: got stall %0d data %h expected 24 31111111", st, rd); end
    checks++; if (wb_count != 1 || last_wb_addr !== 32'h000) begin errors++; $display("FAIL wb_addr: got wb %0d @%h expected 1 @0", wb_count, last_wb_addr); end
    checks++; if (last_wb_data[63:0] !== 64'h22222222_DEADBEEF) begin errors++; $display("FAIL wb_data: got %h expected 22222222deadbeef", last_wb_data[63:0]); end
    checks++; if (last_rf_addr !== 32'h400 || miss_cnt !== 32'd3 || hit_cnt !== 32'd5) begin errors++; $display("FAIL evict_cnt: got rf@%h miss %0d hit %0d expected 400 3 5", last_rf_addr, miss_cnt, hit_cnt); end
  endtask

  task automatic test_lru_keep();
    int st, en0; logic [31:0] rd;
    en0 = en_cycles;
    access(32'h200, 32'h0, 1'b1, 1'b0, st, rd);
    checks++; if (st != 0 || rd !== 32'h01111111) begin errors++; $display("FAIL lru_hit: got stall %0d data %h expected 0 01111111", st, rd); end
    checks++; if (en_cycles != en0 || hit_cnt !== 32'd6) begin errors++; $display("FAIL lru_traffic: got en %0d hit %0d expected %0d 6", en_cycles, hit_cnt, en0); end
  endtask

  task automatic test_ack_ignored();
    int st, en0, wb0; logic [31:0] rd;
    en0 = en_cycles; wb0 = wb_count;
    spur_ack = 1'b1;
    @(posedge clk); #1;
    spur_ack = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.mem_enable_o !== 1'b0) begin errors++; $display("FAIL spur_enable: got %b expected 0", bus.mem_enable_o); end
    access(32'h400, 32'h0, 1'b1, 1'b0, st, rd);
    checks++; if (st != 0 || rd !== 32'h31111111 || en_cycles != en0 || wb_count != wb0) begin errors++; $display("FAIL spur_hit: got stall %0d data %h en %0d expected 0 31111111 %0d", st, rd, en_cycles, en0); end
  endtask

  task automatic test_reset_mid_miss();
    int st, wb0; logic [31:0] rd;
    access(32'h404, 32'hCAFEF00D, 1'b0, 1'b1, st, rd);
    wb0 = wb_count;
    bus.p1_addr_i = 32'h040; bus.p1_MemRead_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bus.mem_enable_o !== 1'b1 || bus.mem_write_o !== 1'b0 || bus.mem_addr_o !== 32'h040) begin errors++; $display("FAIL refill_req: got en %b wr %b @%h expected 1 0 @040", bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o); end
    @(negedge clk) rst = 1'b1;
    #1;
    checks++; if (bus.mem_enable_o !== 1'b0 || bus.p1_stall_o !== 1'b0) begin errors++; $display("FAIL rst_abort: got en %b stall %b expected 0 0", bus.mem_enable_o, bus.p1_stall_o); end
    bus.p1_MemRead_i = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("FAIL rst_abort_cnt: got hit %0d miss %0d expected 0 0", hit_cnt, miss_cnt); end
    access(32'h004, 32'h0, 1'b1, 1'b0, st, rd);
    checks++; if (st != 13 || rd !== 32'h22222222) begin errors++; $display("FAIL reload: got stall %0d data %h expected 13 22222222", st, rd); end
    checks++; if (wb_count != wb0 || miss_cnt !== 32'd1 || hit_cnt !== 32'd1) begin errors++; $display("FAIL reload_cnt: got wb %0d miss %0d hit %0d expected %0d 1 1", wb_count, miss_cnt, hit_cnt, wb0); end
  endtask

  task automatic test_rw_both();
    int st; logic [31:0] rd;
    access(32'h020, 32'h5A5A5A5A, 1'b1, 1'b1, st, rd);
    checks++; if (st != 13 || miss_cnt !== 32'd2 || hit_cnt !== 32'd2) begin errors++; $display("FAIL rw_store: got stall %0d miss %0d hit %0d expected 13 2 2", st, miss_cnt, hit_cnt); end
    access(32'h020, 32'h0, 1'b1, 1'b0, st, rd);
    checks++; if (st != 0 || rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL rw_load: got stall %0d data %h expected 0 5a5a5a5a", st, rd); end
    access(32'h220, 32'h0, 1'b1, 1'b0, st, rd);
    checks++; if (st != 13 || rd !== 32'h00111111) begin errors++; $display("FAIL rw_fill_way1: got stall %0d data %h expected 13 00111111", st, rd); end
    access(32'h420, 32'h0, 1'b1, 1'b0, st, rd);
    checks++; if (st != 24 || rd !== 32'h30111111) begin errors++; $display("FAIL rw_evict: got stall %0d data %h expected 24 30111111", st, rd); end
    checks++; if (last_wb_addr !== 32'h020 || last_wb_data[31:0] !== 32'h5A5A5A5A) begin errors++; $display("FAIL rw_wb: got @%h %h expected @020 5a5a5a5a", last_wb_addr, last_wb_data[31:0]); end
    checks++; if (miss_cnt !== 32'd4 || hit_cnt !== 32'd5) begin errors++; $display("FAIL rw_cnt: got miss %0d hit %0d expected 4 5", miss_cnt, hit_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_hit();
    test_dirty_evict();
    test_lru_keep();
    test_ack_ignored();
    test_reset_mid_miss();
    test_rw_both();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
